rng_arbiter: RTL and testbench

RNG_ARBITER -- requirements
Module: rng_arbiter

---
 rtl/rng_arbiter.sv | 113 +++++++++++
 tb/tb_rng_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_arbiter.sv
// rng_arbiter: two-requester round-robin arbiter that hands out LFSR values.
// Define RNG_FREE_RUN_EN to let the LFSR also advance on every IDLE edge.
module rng_arbiter #(
  parameter int unsigned STEPS = 8,
  parameter logic [7:0]  SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       seed_load,
  input  logic [7:0] seed_in,
  output logic [1:0] gnt,
  output logic [7:0] rnd,
  output logic       rnd_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    GRANT
  } state_t;

  localparam logic [3:0] LAST = 4'(STEPS);

  state_t     r_state;
  logic [7:0] r_lfsr;
  logic [7:0] r_rnd;
  logic [1:0] r_gnt;
  logic       r_vld;
  logic       r_win;
  logic       r_last;
  logic [3:0] r_cnt;

  logic [7:0] w_next;
  logic [7:0] w_seed;
  logic       w_pick;

  assign w_next = {r_lfsr[6:0],
                   r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // A zero seed would lock the LFSR, so fall back to SEED.
  assign w_seed = (seed_in == 8'h00) ? SEED : seed_in;

  always_comb begin
    w_pick = 1'b0;
    unique case (1'b1)
      (req == 2'b11): w_pick = ~r_last;
      (req == 2'b10): w_pick = 1'b1;
      default:        w_pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lfsr  <= SEED;
      r_rnd   <= 8'h00;
      r_gnt   <= 2'b00;
      r_vld   <= 1'b0;
      r_win   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_gnt <= 2'b00;
          r_vld <= 1'b0;
          if (seed_load) begin
            r_lfsr <= w_seed;
          end else begin
`ifdef RNG_FREE_RUN_EN
            r_lfsr <= w_next;
`endif
            if (req != 2'b00) begin
              r_state <= STEP;
              r_win   <= w_pick;
              r_cnt   <= 4'd0;
            end
          end
        end
        STEP: begin
          if (r_cnt == LAST) begin
            r_state <= GRANT;
            r_rnd   <= r_lfsr;
            r_gnt   <= r_win ? 2'b10 : 2'b01;
            r_vld   <= 1'b1;
            r_last  <= r_win;
          end else begin
            r_lfsr <= w_next;
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        GRANT: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
          r_vld   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rnd       = r_rnd;
  assign rnd_valid = r_vld;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed and randomized checks of rng_arbiter
// against a transaction-level reference model.
module tb_rng_arbiter;

  localparam int unsigned TB_STEPS = 1;
  localparam logic [7:0]  TB_SEED  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [1:0] gnt;
  logic [7:0] rnd;
  logic       rnd_valid;
  logic       busy;

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] m_lfsr;
  logic [7:0] m_rnd;
  logic       m_last;
  logic       m_win;
  logic       m_act;
  int         m_k;

  logic [1:0] e_gnt;
  logic       e_vld;
  logic       e_busy;

  rng_arbiter #(
    .STEPS(TB_STEPS),
    .SEED (TB_SEED)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .gnt      (gnt),
    .rnd      (rnd),
    .rnd_valid(rnd_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    m_lfsr = TB_SEED;
    m_rnd  = 8'h00;
    m_last = 1'b1;
    m_win  = 1'b0;
    m_act  = 1'b0;
    m_k    = 0;
    e_gnt  = 2'b00;
    e_vld  = 1'b0;
    e_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 2'b00;
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock edge: update the model with the inputs sampled there.
  task automatic tick();
    @(posedge clk);
    if (m_act) begin
      m_k++;
      if (m_k == TB_STEPS + 1) begin
        m_rnd  = m_lfsr;
        m_last = m_win;
      end
      if (m_k == TB_STEPS + 2) m_act = 1'b0;
    end else if (seed_load) begin
      m_lfsr = (seed_in == 8'h00) ? TB_SEED : seed_in;
    end else begin
`ifdef RNG_FREE_RUN_EN
      m_lfsr = nxt(m_lfsr);
`endif
      if (req != 2'b00) begin
        m_win = (req == 2'b11) ? ~m_last : req[1];
        m_act = 1'b1;
        m_k   = 0;
        for (int s = 0; s < TB_STEPS; s++) m_lfsr = nxt(m_lfsr);
      end
    end
    e_busy = m_act;
    e_vld  = m_act && (m_k == TB_STEPS + 1);
    e_gnt  = e_vld ? (m_win ? 2'b10 : 2'b01) : 2'b00;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tot++;
    if ({gnt, rnd_valid, busy, rnd} !== {2'b00, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_outputs: got %h want %h",
               {gnt, rnd_valid, busy, rnd}, 12'h000);
    else n_pass++;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tot++;
      if ({gnt, busy} !== 3'b000)
        $display("FAIL reset_idle[%0d]: got %b want 000", i, {gnt, busy});
      else n_pass++;
    end
  endtask

`ifndef RNG_FREE_RUN_EN
  task automatic test_basic();
    do_reset();
    req = 2'b01;
    tick();
    n_tot++;
    if ({gnt, rnd_valid, busy} !== 4'b0001)
      $display("FAIL basic_sample: got %b want 0001", {gnt, rnd_valid, busy});
    else n_pass++;
    req = 2'b00;
    tick();
    n_tot++;
    if ({gnt, rnd_valid, busy} !== 4'b0001)
      $display("FAIL basic_step: got %b want 0001", {gnt, rnd_valid, busy});
    else n_pass++;
    tick();
    n_tot++;
    if ({gnt, rnd_valid, busy, rnd} !== {2'b01, 1'b1, 1'b1, 8'h4A})
      $display("FAIL basic_grant0: got %h want %h",
               {gnt, rnd_valid, busy, rnd}, {2'b01, 1'b1, 1'b1, 8'h4A});
    else n_pass++;
    tick();
    n_tot++;
    if ({gnt, rnd_valid, busy, rnd} !== {2'b00, 1'b0, 1'b0, 8'h4A})
      $display("FAIL basic_hold: got %h want %h",
               {gnt, rnd_valid, busy, rnd}, {2'b00, 1'b0, 1'b0, 8'h4A});
    else n_pass++;
    req = 2'b10;
    tick();
    req = 2'b00;
    tick();
    tick();
    n_tot++;
    if ({gnt, rnd_valid, rnd} !== {2'b10, 1'b1, 8'h95})
      $display("FAIL basic_grant1: got %h want %h",
               {gnt, rnd_valid, rnd}, {2'b10, 1'b1, 8'h95});
    else n_pass++;
    tick();
  endtask

  task automatic test_seed();
    do_reset();
    seed_in   = 8'h00;
    seed_load = 1'b1;
    req       = 2'b01;
    tick();
    n_tot++;
    if (busy !== 1'b0)
      $display("FAIL seed_defer: got %b want 0", busy);
    else n_pass++;
    seed_load = 1'b0;
    tick();
    req = 2'b00;
    tick();
    tick();
    n_tot++;
    if ({gnt, rnd} !== {2'b01, 8'h4A})
      $display("FAIL seed_zero: got %h want %h", {gnt, rnd}, {2'b01, 8'h4A});
    else n_pass++;
    tick();
    seed_in   = 8'h95;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req       = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    n_tot++;
    if (rnd !== 8'h2A)
      $display("FAIL seed_95: got %h want 2a", rnd);
    else n_pass++;
    tick();
    seed_in   = 8'h4A;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req       = 2'b10;
    tick();
    req = 2'b00;
    tick();
    tick();
    n_tot++;
    if ({gnt, rnd} !== {2'b10, 8'h95})
      $display("FAIL seed_4a: got %h want %h", {gnt, rnd}, {2'b10, 8'h95});
    else n_pass++;
    tick();
  endtask
`else
  task automatic test_free_run();
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    n_tot++;
    if ({gnt, rnd_valid, rnd} !== {2'b01, 1'b1, 8'h95})
      $display("FAIL free_run: got %h want %h",
               {gnt, rnd_valid, rnd}, {2'b01, 1'b1, 8'h95});
    else n_pass++;
    tick();
  endtask
`endif

  task automatic test_round_robin();
    int per;
    logic [1:0] xg;
    logic       xb;
    per = TB_STEPS + 3;
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 4 * per; k++) begin
      tick();
      xg = 2'b00;
      if (k % per == TB_STEPS + 1) xg = ((k / per) % 2 == 1) ? 2'b10 : 2'b01;
      xb = (k % per != TB_STEPS + 2);
      n_tot++;
      if ({gnt, busy} !== {xg, xb})
        $display("FAIL rr[%0d]: got %b want %b", k, {gnt, busy}, {xg, xb});
      else n_pass++;
    end
    req = 2'b00;
    repeat (per) tick();
  endtask

  task automatic test_drop_and_hold();
    do_reset();
    req = 2'b01;
    tick();
    req       = 2'b00;
    seed_load = 1'b1;
    seed_in   = 8'h01;
    for (int i = 0; i < TB_STEPS + 1; i++) begin
      tick();
      n_tot++;
      if ({gnt, rnd_valid, busy, rnd} !== {e_gnt, e_vld, e_busy, m_rnd})
        $display("FAIL drop[%0d]: got %h want %h", i,
                 {gnt, rnd_valid, busy, rnd}, {e_gnt, e_vld, e_busy, m_rnd});
      else n_pass++;
    end
    seed_load = 1'b0;
    req       = 2'b10;
    for (int i = 0; i < 2 * (TB_STEPS + 3); i++) begin
      tick();
      n_tot++;
      if ({gnt, rnd_valid, busy, rnd} !== {e_gnt, e_vld, e_busy, m_rnd})
        $display("FAIL hold[%0d]: got %h want %h", i,
                 {gnt, rnd_valid, busy, rnd}, {e_gnt, e_vld, e_busy, m_rnd});
      else n_pass++;
    end
    req = 2'b00;
    repeat (TB_STEPS + 3) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b00;
    repeat (TB_STEPS + 2) tick();
    req = 2'b10;
    tick();
    req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    n_tot++;
    if ({gnt, rnd_valid, busy, rnd} !== {2'b00, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_mid: got %h want %h",
               {gnt, rnd_valid, busy, rnd}, 12'h000);
    else n_pass++;
    for (int i = 0; i < TB_STEPS + 2; i++) begin
      @(posedge clk);
      #1;
      n_tot++;
      if ({gnt, rnd_valid, busy} !== 4'b0000)
        $display("FAIL reset_hold[%0d]: got %b want 0000", i,
                 {gnt, rnd_valid, busy});
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req       = 2'($urandom_range(0, 3));
      seed_load = ($urandom_range(0, 7) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
      n_tot++;
      if ({gnt, rnd_valid, busy, rnd} !== {e_gnt, e_vld, e_busy, m_rnd})
        $display("FAIL rand[%0d]: got %h want %h", i,
                 {gnt, rnd_valid, busy, rnd}, {e_gnt, e_vld, e_busy, m_rnd});
      else n_pass++;
    end
    req       = 2'b00;
    seed_load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
`ifndef RNG_FREE_RUN_EN
    test_basic();
    test_seed();
`else
    test_free_run();
`endif
    test_round_robin();
    test_drop_and_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
